ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  Parametrised successor to the EX ALU-source mux: forms both ALU operands for EX from register
//  data, immediates and forwarded results. Registers the operands behind a valid/ready handshake.
//  Stalls on load-use hazards and supports flush. Sits between ID/EX pipeline register and ALU.
// PARAMETERS
//  DATA_W    32  operand/data width
//  IMM_W     16  instruction immediate width (DATA_W >= IMM_W)
//  NUM_FWD    2  forwarding sources; index 0 = youngest (EX/MEM), highest priority
//  REG_AW     5  register-address width; address 0 is never forwarded
//  STALL_CW  16  hazard-stall counter width
// PORTS
//  Clk             in   1                  clock, rising edge
//  Reset_n         in   1                  asynchronous reset, active-low
//  In_Valid        in   1                  ID/EX presents an instruction
//  In_Ready        out  1                  stage accepts this cycle
//  Rs_Addr_EX      in   REG_AW             source-A register number
//  Rt_Addr_EX      in   REG_AW             source-B register number
//  Read_Data_1_EX  in   DATA_W             register-file data A
//  Read_Data_2_EX  in   DATA_W             register-file data B
//  Imm_EX          in   IMM_W              raw immediate
//  Shamt_EX        in   $clog2(DATA_W)     shift amount
//  ALUSrcA_EX      in   1                  0 = reg A, 1 = zero-extended Shamt_EX
//  ALUSrcB_EX      in   3                  0 reg B, 1 sign-ext imm, 2 zero-ext imm, 3 imm<<(DATA_W-IMM_W); 4-7 -> reg B
//  Fwd_Valid       in   NUM_FWD            source i holds a register write
//  Fwd_Pending     in   NUM_FWD            source i write data not yet available (load)
//  Fwd_Addr        in   NUM_FWD*REG_AW     destination register, source i at [i*REG_AW +: REG_AW]
//  Fwd_Data        in   NUM_FWD*DATA_W     write data, source i at [i*DATA_W +: DATA_W]
//  Flush           in   1                  kill held and incoming instruction
//  Out_Valid       out  1                  operands valid to ALU
//  Out_Ready       in   1                  ALU consumes this cycle
//  ALU_Data_1_EX   out  DATA_W             operand A (registered)
//  ALU_Data_2_EX   out  DATA_W             operand B (registered)
//  Store_Data_EX   out  DATA_W             forwarded reg B, always, for sw (registered)
//  Stall_Count     out  STALL_CW           cycles lost to hazards, saturating
// BEHAVIOUR
//  - Reset (Reset_n=0, async): Out_Valid=0, ALU_Data_1/2_EX=0, Store_Data_EX=0, Stall_Count=0.
//  - Forwarding (comb): match_i = Fwd_Valid[i] & Fwd_Addr_i==addr & addr!=0.
//    Lowest matching i wins. No match -> Read_Data_x_EX.
//  - Hazard: winning match for a used source has Fwd_Pending=1.
//    Rs is used when ALUSrcA_EX=0. Rt is always used (Store_Data_EX).
//    Pending on a non-winning lower-priority match is ignored.
//  - In_Ready = (!Out_Valid | Out_Ready) & !hazard. Hazard is evaluated only when In_Valid=1.
//  - Accept (In_Valid & In_Ready): next edge loads all three outputs, Out_Valid=1. Latency 1 cycle.
//  - Hold: Out_Valid & !Out_Ready -> outputs and Out_Valid stable.
//  - Drain: Out_Ready & !accept -> Out_Valid=0; data regs keep their last value.
//  - Back-to-back: Out_Ready & accept in the same cycle -> new operands next edge, no bubble.
//  - Flush: overrides everything. Next edge Out_Valid=0; the incoming instruction is dropped.
//    In_Ready still reports its formula; the ID side treats Flush as consumed.
//  - Stall_Count: +1 per cycle with In_Valid & hazard & !Flush. Saturates at all-ones, no wrap.
//  - Immediates: sign-ext replicates Imm_EX[IMM_W-1]. Zero-ext pads 0s.
//    Mode 3 = {Imm_EX, (DATA_W-IMM_W)'b0}, i.e. LUI.
//  - Reset mid-transfer: held instruction lost, Out_Valid=0 immediately (async).
//  - Everything is combinational except the output registers and Stall_Count.
// STRUCTURE
//  - Shared package/header: ALUSrcB encodings (SRCB_REG, SRCB_SEXT, SRCB_ZEXT, SRCB_LUI).
//  - One sub-module, fwd_select: parametrised priority match over NUM_FWD for one address.
//    Outputs data, hit and pending. Instantiated twice (Rs, Rt).
// TESTING
//  1. Reset, then In_Valid with Rs=3 (0x11), ALUSrcA=0, ALUSrcB=1, Imm=0xFFF0, no fwd
//     -> next cycle Out_Valid=1, A=0x00000011, B=0xFFFFFFF0.
//  2. Fwd0 and Fwd1 both target Rt=7 (0xAAAA / 0xBBBB), ALUSrcB=0
//     -> B=0xAAAA, Store_Data_EX=0xAAAA. Repeat with Rt=0 -> Read_Data_2_EX used.
//  3. Fwd0 Pending on Rs=4 for 2 cycles, ALUSrcA=0
//     -> In_Ready=0 two cycles, Stall_Count=2; clear Pending -> accept, A=Fwd_Data0.
//  4. Out_Ready=0 for 3 cycles with a new In_Valid
//     -> outputs stable, In_Ready=0. Out_Ready=1 -> new operands next edge, no bubble.
//  5. Flush while Out_Valid=1 and In_Valid=1 -> Out_Valid=0 next edge, new instruction dropped.
//     ALUSrcB=3, Imm=0x1234 -> B=0x12340000.
//  6. Force Stall_Count near max (STALL_CW=4), hold hazard 20 cycles
//     -> saturates at 0xF. Assert Reset_n=0 mid-hold -> Out_Valid and Stall_Count 0 asynchronously.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg
//   Shared definitions for the EX operand stage: ALUSrcB select encodings.
//   Codes 4-7 are not listed and select register B, same as SRCB_REG.
package ex_operand_stage_pkg;

    localparam logic [2:0] SRCB_REG  = 3'd0;  // forwarded register B
    localparam logic [2:0] SRCB_SEXT = 3'd1;  // sign-extended immediate
    localparam logic [2:0] SRCB_ZEXT = 3'd2;  // zero-extended immediate
    localparam logic [2:0] SRCB_LUI  = 3'd3;  // immediate in the upper bits

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// fwd_select
//   Priority forwarding match for one source register address.
//   Source 0 is the youngest result and wins over all others. Register 0
//   is hard-wired and never forwarded.
// Ports
//   addr        in   REG_AW            source register number
//   rf_data     in   DATA_W            register-file data for addr
//   fwd_valid   in   NUM_FWD           source i holds a register write
//   fwd_pending in   NUM_FWD           source i data not yet available
//   fwd_addr    in   NUM_FWD*REG_AW    destination of source i
//   fwd_data    in   NUM_FWD*DATA_W    write data of source i
//   data        out  DATA_W            forwarded or register-file data
//   hit         out  1                 some source matched
//   pending     out  1                 the winning source is still pending
module fwd_select #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         data,
    output logic                      hit,
    output logic                      pending
);

    // Walk from the oldest source to the youngest so the lowest index
    // overwrites any older match; pending follows the winner only.
    always_comb begin
        data    = rf_data;
        hit     = 1'b0;
        pending = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == addr) && (addr != '0)) begin
                data    = fwd_data[i*DATA_W +: DATA_W];
                hit     = 1'b1;
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   Forms both ALU operands for EX from register data, immediates and
//   forwarded results, and registers them behind a valid/ready handshake.
//   Stalls while a used source waits on a load; Flush kills the held and
//   incoming instruction.
// Ports
//   Clk, Reset_n                  clock (rising edge), async active-low reset
//   In_Valid / In_Ready           upstream handshake from ID/EX
//   Rs_Addr_EX, Rt_Addr_EX        source register numbers
//   Read_Data_1_EX/2_EX           register-file data A / B
//   Imm_EX, Shamt_EX              raw immediate and shift amount
//   ALUSrcA_EX, ALUSrcB_EX        operand selects
//   Fwd_Valid/Pending/Addr/Data   forwarding sources, index 0 youngest
//   Flush                         kill held and incoming instruction
//   Out_Valid / Out_Ready         downstream handshake to the ALU
//   ALU_Data_1_EX/2_EX            registered operands A / B
//   Store_Data_EX                 registered forwarded register B
//   Stall_Count                   saturating count of hazard cycles
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 16,
    parameter int NUM_FWD  = 2,
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        In_Valid,
    output logic                        In_Ready,
    input  logic [REG_AW-1:0]           Rs_Addr_EX,
    input  logic [REG_AW-1:0]           Rt_Addr_EX,
    input  logic [DATA_W-1:0]           Read_Data_1_EX,
    input  logic [DATA_W-1:0]           Read_Data_2_EX,
    input  logic [IMM_W-1:0]            Imm_EX,
    input  logic [$clog2(DATA_W)-1:0]   Shamt_EX,
    input  logic                        ALUSrcA_EX,
    input  logic [2:0]                  ALUSrcB_EX,
    input  logic [NUM_FWD-1:0]          Fwd_Valid,
    input  logic [NUM_FWD-1:0]          Fwd_Pending,
    input  logic [NUM_FWD*REG_AW-1:0]   Fwd_Addr,
    input  logic [NUM_FWD*DATA_W-1:0]   Fwd_Data,
    input  logic                        Flush,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic [DATA_W-1:0]           ALU_Data_1_EX,
    output logic [DATA_W-1:0]           ALU_Data_2_EX,
    output logic [DATA_W-1:0]           Store_Data_EX,
    output logic [STALL_CW-1:0]         Stall_Count
);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              hit_a;
    logic              hit_b;
    logic              pend_a;
    logic              pend_b;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs (
        .addr        (Rs_Addr_EX),
        .rf_data     (Read_Data_1_EX),
        .fwd_valid   (Fwd_Valid),
        .fwd_pending (Fwd_Pending),
        .fwd_addr    (Fwd_Addr),
        .fwd_data    (Fwd_Data),
        .data        (fwd_a),
        .hit         (hit_a),
        .pending     (pend_a)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rt (
        .addr        (Rt_Addr_EX),
        .rf_data     (Read_Data_2_EX),
        .fwd_valid   (Fwd_Valid),
        .fwd_pending (Fwd_Pending),
        .fwd_addr    (Fwd_Addr),
        .fwd_data    (Fwd_Data),
        .data        (fwd_b),
        .hit         (hit_b),
        .pending     (pend_b)
    );

    // Rt is always consumed because Store_Data_EX carries it even when
    // operand B comes from the immediate.
    assign hazard   = In_Valid & (((~ALUSrcA_EX) & hit_a & pend_a) | (hit_b & pend_b));
    assign In_Ready = (~Out_Valid | Out_Ready) & ~hazard;
    assign accept   = In_Valid & In_Ready;

    assign operand_a = ALUSrcA_EX ? DATA_W'(Shamt_EX) : fwd_a;

    always_comb begin
        operand_b = fwd_b;
        case (ALUSrcB_EX)
            SRCB_SEXT: operand_b = DATA_W'($signed(Imm_EX));
            SRCB_ZEXT: operand_b = DATA_W'(Imm_EX);
            SRCB_LUI:  operand_b = DATA_W'(Imm_EX) << (DATA_W - IMM_W);
            default:   operand_b = fwd_b;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid     <= 1'b0;
            ALU_Data_1_EX <= '0;
            ALU_Data_2_EX <= '0;
            Store_Data_EX <= '0;
        end else if (Flush) begin
            Out_Valid <= 1'b0;
        end else if (accept) begin
            Out_Valid     <= 1'b1;
            ALU_Data_1_EX <= operand_a;
            ALU_Data_2_EX <= operand_b;
            Store_Data_EX <= fwd_b;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Stall_Count <= '0;
        end else if (hazard && !Flush && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + STALL_CW'(1);
        end
    end

endmodule
